// File: rtl/mem_resp_queue_pkg.sv
`default_nettype none
// ============================================================================
//  mem_resp_queue_pkg
//  Shared encodings and metadata layout for the MEM-stage response tracker
//  and its load-extension datapath.
//  Revision: 1.0 - initial multi-outstanding release
// ============================================================================
package mem_resp_queue_pkg;

  // Access size encodings carried with each request
  localparam logic [1:0] MEM_SZ_B = 2'b00;
  localparam logic [1:0] MEM_SZ_H = 2'b01;
  localparam logic [1:0] MEM_SZ_W = 2'b10;

  // Per-request access metadata recorded at allocation time
  typedef struct packed {
    logic       is_load;
    logic [1:0] size;
    logic       uns;
    logic [1:0] addr_low;
  } mem_meta_t;

  localparam int MEM_META_W = $bits(mem_meta_t);

endpackage
`default_nettype wire

// File: rtl/mem_resp_queue_load_extend.sv
`default_nettype none
// ============================================================================
//  mem_resp_queue_load_extend
//  Combinational lane select and sign/zero extension of SRAM read data.
//  Stores and misaligned halfwords produce zero.
//  Revision: 1.0 - initial release
// ============================================================================
module mem_resp_queue_load_extend
  import mem_resp_queue_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic        is_load,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  addr_low,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select the addressed lane and extend it to 32 bits
  always_comb begin
    data   = '0;
    lane_b = rdata[8*addr_low +: 8];
    lane_h = (addr_low[1]) ? rdata[31:16] : rdata[15:0];
    if (is_load) begin
      case (size)
        MEM_SZ_B: data = {{24{~uns & lane_b[7]}}, lane_b};
        MEM_SZ_H: begin
          // Odd halfword addresses raise ALE upstream; return zero here
          if (!addr_low[0]) data = {{16{~uns & lane_h[15]}}, lane_h};
        end
        MEM_SZ_W: data = rdata;
        default:  data = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_resp_queue.sv
`default_nettype none
// ============================================================================
//  mem_resp_queue
//  In-order tracker for up to DEPTH outstanding data-SRAM transactions.
//  Records request metadata, captures data_ok responses, holds them until
//  WB accepts, drops responses owed to flushed requests, and extends loads.
//  Revision: 1.0 - multi-outstanding replacement of single-entry tracker
// ============================================================================
module mem_resp_queue
  import mem_resp_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_allowin,
  input  logic             req_is_load,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [1:0]       req_addr_low,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_load,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [PTR_W-1:0] alloc_ptr, resp_ptr, head_ptr;
  logic [CNT_W-1:0] occ, pend, discard_cnt;
  logic [DEPTH-1:0] done;

  mem_meta_t   meta_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  mem_meta_t   req_meta, head_meta;
  logic        owe_none, do_alloc, do_capture, bypass, do_retire;
  logic [31:0] head_rdata, ext_data;

  assign req_meta = {req_is_load, req_size, req_unsigned, req_addr_low};

  // Control decode: allocation, capture, same-cycle bypass and retirement
  always_comb begin
    owe_none    = (discard_cnt == '0);
    do_alloc    = req_valid && !flush;
    do_capture  = data_ok && !flush && owe_none;
    bypass      = data_ok && owe_none && (pend != '0) && (resp_ptr == head_ptr);
    out_valid   = !flush && (done[head_ptr] || bypass);
    do_retire   = out_valid && out_ready;
    head_meta   = meta_mem[head_ptr];
    head_rdata  = done[head_ptr] ? data_mem[head_ptr] : rdata;
    out_data    = out_valid ? ext_data : '0;
    out_is_load = out_valid && head_meta.is_load;
    // Bus outstanding = tracked entries plus responses still owed for flushed ones
    req_allowin = ({1'b0, occ} + {1'b0, discard_cnt}) < (CNT_W+1)'(DEPTH);
    occupancy   = occ;
  end

  mem_resp_queue_load_extend u_load_extend (
    .rdata    (head_rdata),
    .is_load  (head_meta.is_load),
    .size     (head_meta.size),
    .uns      (head_meta.uns),
    .addr_low (head_meta.addr_low),
    .data     (ext_data)
  );

  // Pointers, counters and done flags; flush wins over all other updates
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr   <= '0;
      resp_ptr    <= '0;
      head_ptr    <= '0;
      occ         <= '0;
      pend        <= '0;
      discard_cnt <= '0;
      done        <= '0;
    end else if (flush) begin
      alloc_ptr   <= '0;
      resp_ptr    <= '0;
      head_ptr    <= '0;
      occ         <= '0;
      pend        <= '0;
      done        <= '0;
      // Every live request plus any new one becomes an owed, dropped response
      discard_cnt <= discard_cnt + pend + CNT_W'(req_valid) - CNT_W'(data_ok);
    end else begin
      if (do_alloc)   alloc_ptr <= alloc_ptr + PTR_W'(1);
      if (do_capture) resp_ptr  <= resp_ptr + PTR_W'(1);
      if (do_retire)  head_ptr  <= head_ptr + PTR_W'(1);
      occ  <= occ + CNT_W'(do_alloc) - CNT_W'(do_retire);
      pend <= pend + CNT_W'(do_alloc) - CNT_W'(do_capture);
      if (data_ok && !owe_none) discard_cnt <= discard_cnt - CNT_W'(1);
      if (do_alloc)  done[alloc_ptr] <= 1'b0;
      if (do_retire) done[head_ptr]  <= 1'b0;
      // A bypassed response retired in its own cycle never becomes done
      if (do_capture && !(bypass && do_retire)) done[resp_ptr] <= 1'b1;
    end
  end

  // Entry payload storage; no reset needed since done gates its use
  always_ff @(posedge clk) begin
    if (do_alloc)   meta_mem[alloc_ptr] <= req_meta;
    if (do_capture) data_mem[resp_ptr]  <= rdata;
  end

`ifndef SYNTHESIS
  // Upstream protocol checks: no overwrite, no over-issue, no stray response
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(do_alloc && occ == CNT_W'(DEPTH)));
      assert (!(req_valid && !req_allowin));
      assert (!(data_ok && owe_none && pend == '0));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_resp_queue.sv
`default_nettype none
// ============================================================================
//  tb_mem_resp_queue
//  Self-checking bench: transaction-level reference model (tracked entries
//  and owed bus responses as queues) compared every cycle, plus directed
//  literal expectations for the main scenarios.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_mem_resp_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_is_load, req_unsigned;
  logic [1:0]       req_size, req_addr_low;
  logic             data_ok, flush, out_ready;
  logic [31:0]      rdata;
  logic             req_allowin, out_valid, out_is_load;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] occupancy;

  always #5 clk = ~clk;

  mem_resp_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_allowin  (req_allowin),
    .req_is_load  (req_is_load),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr_low (req_addr_low),
    .data_ok      (data_ok),
    .rdata        (rdata),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_is_load  (out_is_load),
    .out_data     (out_data),
    .occupancy    (occupancy)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_load;
    bit [1:0]    size;
    bit          uns;
    bit [1:0]    addr;
    bit          has_data;
    logic [31:0] data;
  } ent_t;

  ent_t trk[$];   // requests allocated and not yet retired, oldest first
  bit   bus[$];   // responses owed by the bus in order; 1 = cancelled

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 0;

  function automatic logic [31:0] model_ext(bit ld, bit [1:0] sz, bit un, bit [1:0] al, logic [31:0] d);
    longint v;
    if (!ld) return 32'h0;
    if (sz == 2'b00) begin
      v = (longint'(d) >> (8 * al)) % 256;
      if (!un && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      if (al == 2'd0)      v = longint'(d) % 65536;
      else if (al == 2'd2) v = longint'(d) / 65536;
      else return 32'h0;
      if (!un && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(d);
    end
    return v[31:0];
  endfunction

  function automatic int n_cancel();
    int n = 0;
    foreach (bus[i]) if (bus[i]) n++;
    return n;
  endfunction

  function automatic bit model_allow();
    return (trk.size() + n_cancel()) < DEPTH;
  endfunction

  function automatic void model_out(output bit v, output bit ld, output logic [31:0] d);
    v = 0; ld = 0; d = 32'h0;
    if (flush || trk.size() == 0) return;
    if (trk[0].has_data) begin
      v = 1;
      d = model_ext(trk[0].is_load, trk[0].size, trk[0].uns, trk[0].addr, trk[0].data);
    end else if (data_ok && bus.size() > 0 && !bus[0]) begin
      v = 1;
      d = model_ext(trk[0].is_load, trk[0].size, trk[0].uns, trk[0].addr, rdata);
    end
    if (v) ld = trk[0].is_load;
  endfunction

  // Advance the model on each clock from the applied inputs
  always @(posedge clk) begin : model_upd
    bit          v, ld, c;
    logic [31:0] d;
    ent_t        e;
    if (reset) begin
      trk.delete();
      bus.delete();
    end else begin
      model_out(v, ld, d);
      if (flush) begin
        if (data_ok && bus.size() > 0) c = bus.pop_front();
        foreach (bus[i]) bus[i] = 1'b1;
        if (req_valid) bus.push_back(1'b1);
        trk.delete();
      end else begin
        if (data_ok && bus.size() > 0) begin
          c = bus.pop_front();
          if (!c) begin
            for (int i = 0; i < trk.size(); i++) begin
              if (!trk[i].has_data) begin
                e = trk[i];
                e.has_data = 1'b1;
                e.data = rdata;
                trk[i] = e;
                break;
              end
            end
          end
        end
        if (v && out_ready) e = trk.pop_front();
        if (req_valid) begin
          e.is_load = req_is_load; e.size = req_size; e.uns = req_unsigned;
          e.addr = req_addr_low; e.has_data = 1'b0; e.data = 32'h0;
          trk.push_back(e);
          bus.push_back(1'b0);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin : cmp
    bit          v, ld;
    logic [31:0] d;
    if (check_en && !reset) begin
      model_out(v, ld, d);
      chk("out_valid", 32'(out_valid), 32'(v));
      chk("out_is_load", 32'(out_is_load), 32'(ld));
      chk("out_data", out_data, d);
      chk("req_allowin", 32'(req_allowin), 32'(model_allow()));
      chk("occupancy", 32'(occupancy), 32'(trk.size()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(bit rv, bit ld, bit [1:0] sz, bit un, bit [1:0] al,
                        bit dok, logic [31:0] rd, bit fl, bit ordy);
    req_valid = rv; req_is_load = ld; req_size = sz; req_unsigned = un;
    req_addr_low = al; data_ok = dok; rdata = rd; flush = fl; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_w(bit ordy);
    set_in(1, 1, 2'b10, 0, 2'b00, 0, 32'h0, 0, ordy);
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int gap, issued, budget;
    bit rv, dok, fl;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    repeat (2) step();
    reset = 1'b0;
    check_en = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_allowin", 32'(req_allowin), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    step();

    // Back-to-back loads with bypass delivery
    set_in(1, 1, 2'b00, 0, 2'b11, 0, 32'h0, 0, 1); step();
    set_in(1, 1, 2'b01, 1, 2'b10, 1, 32'h80FF_0000, 0, 1); #2;
    chk("ldb_valid", 32'(out_valid), 32'd1);
    chk("ldb_data", out_data, 32'hFFFF_FF80);
    step();
    set_in(1, 1, 2'b10, 0, 2'b00, 1, 32'h8001_1234, 0, 1); #2;
    chk("ldhu_data", out_data, 32'h0000_8001);
    step();
    set_in(1, 0, 2'b10, 0, 2'b00, 1, 32'hDEAD_BEEF, 0, 1); #2;
    chk("ldw_data", out_data, 32'hDEAD_BEEF);
    step();
    set_in(0, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 1); #2;
    chk("st_valid", 32'(out_valid), 32'd1);
    chk("st_is_load", 32'(out_is_load), 32'd0);
    chk("st_data", out_data, 32'h0);
    step();

    // WB stall: fill, buffer, then drain in order
    for (int i = 0; i < 4; i++) ld_w(0);
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0, 0); #2;
    chk("stall_allowin", 32'(req_allowin), 32'd0);
    chk("stall_occ", 32'(occupancy), 32'd4);
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 32'hC0DE_0000 + 32'(i), 0, 0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 32'h0, 0, 1); #2;
      chk("drain_data", out_data, 32'hC0DE_0000 + 32'(i));
      chk("drain_allowin", 32'(req_allowin), (i == 0) ? 32'd0 : 32'd1);
      step();
    end

    // Flush with three pending plus a new request
    for (int i = 0; i < 3; i++) ld_w(1);
    set_in(1, 1, 2'b10, 0, 2'b00, 0, 32'h0, 1, 1); #2;
    chk("flush_valid", 32'(out_valid), 32'd0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0, 1); #2;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_allowin", 32'(req_allowin), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(i == 1, 1, 2'b10, 0, 2'b00, 1, 32'hBAD0_0000 + 32'(i), 0, 1); #2;
      chk("drop_valid", 32'(out_valid), 32'd0);
      step();
    end
    set_in(0, 0, 0, 0, 0, 1, 32'h5555_AAAA, 0, 1); #2;
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_data", out_data, 32'h5555_AAAA);
    step();

    // Flush coincident with data_ok while two are pending
    ld_w(1); ld_w(1);
    set_in(0, 0, 0, 0, 0, 1, 32'hBAD1_0000, 1, 1); step();
    set_in(0, 0, 0, 0, 0, 1, 32'hBAD2_0000, 0, 1); #2;
    chk("drop1_valid", 32'(out_valid), 32'd0);
    step();
    ld_w(1);
    set_in(0, 0, 0, 0, 0, 1, 32'h1357_9BDF, 0, 1); #2;
    chk("after_drop1", out_data, 32'h1357_9BDF);
    step();

    // Reset mid-operation: two pending, one owed discard
    ld_w(1);
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 1, 1); step();
    ld_w(1); ld_w(1);
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    reset = 1'b1; step(); reset = 1'b0; #2;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_occ", 32'(occupancy), 32'd0);
    chk("midrst_allowin", 32'(req_allowin), 32'd1);
    step();

    // Random phase A: ten loads, random gaps and WB back-pressure
    gap = 0; issued = 0; budget = 0;
    while ((issued < 10 || trk.size() > 0 || bus.size() > 0) && budget < 300) begin
      rv  = (issued < 10) && model_allow() && ($urandom_range(0, 1) == 1);
      dok = (bus.size() > 0) && (gap == 0);
      set_in(rv, 1, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), dok, $urandom, 0, 1'($urandom_range(0, 1)));
      if (rv) issued++;
      if (dok) gap = $urandom_range(0, 3); else if (gap > 0) gap--;
      budget++;
      step();
    end
    if (budget >= 300) chk("phaseA_timeout", 32'd1, 32'd0);

    // Random phase B: loads, stores and occasional flushes
    for (int n = 0; n < 400; n++) begin
      rv  = model_allow() && ($urandom_range(0, 2) != 0);
      dok = (bus.size() > 0) && ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 29) == 0);
      set_in(rv, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), dok, $urandom,
             fl, 1'($urandom_range(0, 3) != 0));
      step();
    end

    // Drain everything still outstanding
    budget = 0;
    while ((trk.size() > 0 || bus.size() > 0) && budget < 100) begin
      set_in(0, 0, 0, 0, 0, bus.size() > 0, $urandom, 0, 1);
      budget++;
      step();
    end
    if (budget >= 100) chk("drain_timeout", 32'd1, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0, 1); #2;
    chk("final_occ", 32'(occupancy), 32'd0);
    chk("final_allowin", 32'(req_allowin), 32'd1);
    step();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
